// File: rtl/seq_alu_flags.sv
// Sequential ALU with registered result and flags.
// Arithmetic and logic ops finish in one cycle. Shifts and rotates move one
// bit per cycle. A stored carry (cs) feeds ADC/SBC and is updated by every
// operation that completes.
module seq_alu_flags #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] ONE = 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic             cs;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic [1:0]       sop;

    logic             accept;
    logic             cin;
    logic [WIDTH:0]   add_s, sub_s;
    logic             add_v, sub_v;
    logic [WIDTH-1:0] c_res, c_fsrc;
    logic             c_c, c_v;
    logic             is_shift;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] sh_next;
    logic             sh_out;

    // A retiring result frees the block in the same cycle, so there is no bubble.
    assign in_ready  = !rst && ((state == IDLE) || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign is_shift  = (op[3:2] == 2'b10);
    assign amt       = b[SHW-1:0];

    // Single-cycle datapath; CMP takes its Z/N from the difference, not from result.
    always_comb begin
        cin    = op[1] ? cs : 1'b0;
        add_s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sub_s  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        add_v  = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
        sub_v  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
        c_res  = '0;
        c_c    = 1'b0;
        c_v    = 1'b0;
        case (op)
            4'd0, 4'd2: begin c_res = add_s[WIDTH-1:0]; c_c = add_s[WIDTH]; c_v = add_v; end
            4'd1, 4'd3: begin c_res = sub_s[WIDTH-1:0]; c_c = sub_s[WIDTH]; c_v = sub_v; end
            4'd4:       c_res = a & b;
            4'd5:       c_res = a | b;
            4'd6:       c_res = a ^ b;
            4'd7:       c_res = ~a;
            4'd8, 4'd9, 4'd10, 4'd11: c_res = a;   // zero-length shift
            4'd12:      begin c_res = a; c_c = sub_s[WIDTH]; c_v = sub_v; end
            default:    c_res = '0;
        endcase
        c_fsrc = (op == 4'd12) ? sub_s[WIDTH-1:0] : c_res;
    end

    // One-bit step of the shifter; sh_out is the bit leaving the word.
    always_comb begin
        sh_next = work;
        sh_out  = 1'b0;
        case (sop)
            2'd0: begin sh_next = {work[WIDTH-2:0], 1'b0};         sh_out = work[WIDTH-1]; end
            2'd1: begin sh_next = {1'b0, work[WIDTH-1:1]};         sh_out = work[0];       end
            2'd2: begin sh_next = {work[WIDTH-1], work[WIDTH-1:1]}; sh_out = work[0];      end
            default: begin sh_next = {work[WIDTH-2:0], work[WIDTH-1]}; sh_out = work[WIDTH-1]; end
        endcase
    end

    // Control FSM plus result/flag/stored-carry registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cs       <= 1'b0;
            work     <= '0;
            cnt      <= '0;
            sop      <= 2'd0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            if (is_shift && amt != '0) begin
                state <= SHIFT;
                work  <= a;
                cnt   <= amt;
                sop   <= op[1:0];
            end else begin
                state    <= DONE;
                result   <= c_res;
                zero     <= (c_fsrc == '0);
                negative <= c_fsrc[WIDTH-1];
                carry    <= c_c;
                overflow <= c_v;
                cs       <= c_c;
            end
        end else if (state == SHIFT) begin
            if (cnt == ONE) begin
                state    <= DONE;
                result   <= sh_next;
                zero     <= (sh_next == '0);
                negative <= sh_next[WIDTH-1];
                carry    <= sh_out;
                overflow <= 1'b0;
                cs       <= sh_out;
            end else begin
                work <= sh_next;
                cnt  <= cnt - ONE;
            end
        end else if (state == DONE && out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_seq_alu_flags.sv
// Directed bench for seq_alu_flags at WIDTH=8. Flags are compared packed as
// {zero, carry, negative, overflow}.
module tb_seq_alu_flags;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       zero, carry, negative, overflow;

    int n_chk  = 0;
    int n_fail = 0;

    seq_alu_flags #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry),
        .negative(negative), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {zero, carry, negative, overflow};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure edges until out_valid, then check result/flags.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] x,
                          input logic [7:0] y, input int exp_lat,
                          input logic [7:0] exp_res, input logic [3:0] exp_fl);
        int lat;
        bit got;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        lat = 1;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin got = 1; break; end
            chk({tag, "_busy_in_ready"}, in_ready, 0);
            @(posedge clk);
            lat++;
        end
        chk({tag, "_latency"}, got ? lat : -1, exp_lat);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_flags"}, flags(), exp_fl);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ov_seen;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result, 8'h00);
        chk("rst_flags", flags(), 4'b0000);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Carry chain through Cs
        run_op("add_ff_01", 4'd0, 8'hFF, 8'h01, 1, 8'h00, 4'b1100); retire();
        run_op("adc_10_20", 4'd2, 8'h10, 8'h20, 1, 8'h31, 4'b0000); retire();
        run_op("add_7f_01", 4'd0, 8'h7F, 8'h01, 1, 8'h80, 4'b0011); retire();
        run_op("sub_00_01", 4'd1, 8'h00, 8'h01, 1, 8'hFF, 4'b0110); retire();
        run_op("cmp_10_10", 4'd12, 8'h10, 8'h10, 1, 8'h10, 4'b1000); retire();

        // Multi-cycle shifts
        run_op("sar_81_3", 4'd10, 8'h81, 8'h03, 4, 8'hF0, 4'b0010); retire();
        run_op("rol_81_1", 4'd11, 8'h81, 8'h01, 2, 8'h03, 4'b0100);

        // Hold in DONE with out_ready low while a request waits
        for (int i = 0; i < 3; i++) begin
            op = 4'd2; a = 8'h05; b = 8'h01; in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("hold_result", result, 8'h03);
            chk("hold_flags", flags(), 4'b0100);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        // Retire and accept on the same edge; ADC sees carry from ROL
        out_ready = 1'b1;
        #1 chk("b2b_in_ready", in_ready, 1);
        @(posedge clk);
        #1 out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_out_valid", out_valid, 1);
        chk("b2b_adc_result", result, 8'h07);
        chk("b2b_adc_flags", flags(), 4'b0000);
        retire();
        @(negedge clk);
        chk("b2b_single_accept", out_valid, 0);

        // Set Cs=1, then reset in the middle of a SHL
        run_op("add_ff_01_b", 4'd0, 8'hFF, 8'h01, 1, 8'h00, 4'b1100); retire();
        @(negedge clk);
        op = 4'd8; a = 8'h01; b = 8'h05; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_result", result, 8'h00);
        chk("midrst_flags", flags(), 4'b0000);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_in_ready", in_ready, 1);
        ov_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ov_seen |= out_valid;
        end
        chk("aborted_no_out_valid", ov_seen, 0);
        run_op("adc_01_01", 4'd2, 8'h01, 8'h01, 1, 8'h02, 4'b0000); retire();

        // Reserved opcode
        run_op("op14", 4'd14, 8'hA5, 8'h5A, 1, 8'h00, 4'b1000); retire();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
